// File: rtl/spike_pkg.sv
// Shared types and widths for the spike encoder slice.
package spike_pkg;
  localparam int TS_W  = 8;
  localparam int CNT_W = 8;

  typedef enum logic {
    ARMED,
    REFRACT
  } state_t;
endpackage

// File: rtl/spike_fifo.sv
// First-word-fall-through event queue; DEPTH must be a power of two (>= 2).
module spike_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A push into a full queue still lands when the head leaves on the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/spike_encoder.sv
// Threshold spike encoder with refractory period, timestamped event queue
// and saturating spike counter.
module spike_encoder
  import spike_pkg::*;
#(
  parameter logic [7:0] THRESH_DEFAULT  = 8'd128,
  parameter logic [3:0] REFRACT_DEFAULT = 4'd4,
  parameter int         FIFO_DEPTH      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       membrane,
  input  logic             cfg_we,
  input  logic [7:0]       cfg_thresh,
  input  logic [3:0]       cfg_refract,
  output logic             spike,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [TS_W-1:0]  evt_ts,
  output logic [CNT_W-1:0] spike_count,
  output logic             overflow
);
  state_t          state;
  logic [TS_W-1:0] ts;
  logic [7:0]      thresh;
  logic [3:0]      refract;
  logic [3:0]      rcnt;
  logic            fire;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;

  assign fire      = (state == ARMED) && (membrane >= thresh);
  assign evt_valid = ~fifo_empty;
  assign pop       = evt_valid & evt_ready;

  spike_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TS_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fire),
    .pop   (pop),
    .din   (ts),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (evt_ts)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARMED;
      ts          <= '0;
      thresh      <= THRESH_DEFAULT;
      refract     <= REFRACT_DEFAULT;
      rcnt        <= '0;
      spike       <= 1'b0;
      spike_count <= '0;
      overflow    <= 1'b0;
    end else begin
      ts    <= ts + TS_W'(1);
      spike <= 1'b0;
      if (cfg_we) begin
        thresh  <= cfg_thresh;
        refract <= cfg_refract;
      end
      // Mirrors the queue's drop condition: full with no same-edge pop.
      if (fire && fifo_full && !pop) overflow <= 1'b1;
      case (state)
        ARMED: begin
          if (fire) begin
            spike <= 1'b1;
            rcnt  <= refract;
            if (spike_count != '1) spike_count <= spike_count + CNT_W'(1);
            state <= (refract != '0) ? REFRACT : ARMED;
          end
        end
        REFRACT: begin
          rcnt <= rcnt - 4'd1;
          if (rcnt <= 4'd1) state <= ARMED;
        end
        default: state <= ARMED;
      endcase
    end
  end
endmodule

// File: tb/tb_spike_encoder.sv
// Directed, table-driven bench for spike_encoder with hand sequences for
// queue overflow, counter saturation and mid-refractory reset.
module tb_spike_encoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] membrane = '0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_thresh = '0;
  logic [3:0] cfg_refract = '0;
  logic       spike;
  logic       evt_valid;
  logic       evt_ready = 1'b1;
  logic [7:0] evt_ts;
  logic [7:0] spike_count;
  logic       overflow;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  spike_encoder #(
    .THRESH_DEFAULT  (8'd128),
    .REFRACT_DEFAULT (4'd4),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .membrane    (membrane),
    .cfg_we      (cfg_we),
    .cfg_thresh  (cfg_thresh),
    .cfg_refract (cfg_refract),
    .spike       (spike),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_ts      (evt_ts),
    .spike_count (spike_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mem;
    logic       we;
    logic [7:0] th;
    logic [3:0] rf;
    logic       rdy;
    logic       e_spk;
    logic       e_val;
    logic [7:0] e_cnt;
    logic       chk_ts;
    logic [7:0] e_ts;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t v(input logic [7:0] mem, input logic we, input logic [7:0] th,
                             input logic [3:0] rf, input logic rdy, input logic e_spk,
                             input logic e_val, input logic [7:0] e_cnt, input logic chk_ts,
                             input logic [7:0] e_ts);
    vec_t r;
    r.mem = mem; r.we = we; r.th = th; r.rf = rf; r.rdy = rdy;
    r.e_spk = e_spk; r.e_val = e_val; r.e_cnt = e_cnt; r.chk_ts = chk_ts; r.e_ts = e_ts;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset #1 after an edge, checks the forced state, releases before the next edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    membrane = '0; cfg_we = 1'b0; cfg_thresh = '0; cfg_refract = '0; evt_ready = 1'b1;
    #1;
    check({tag, "_rst_spike"}, spike, 0);
    check({tag, "_rst_valid"}, evt_valid, 0);
    check({tag, "_rst_count"}, spike_count, 0);
    check({tag, "_rst_ovf"}, overflow, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Vector i is sampled while the timestamp equals i.
    tbl[0]  = v(8'd127, 0, 8'd0,   4'd0, 1, 0, 0, 8'd0, 0, 8'd0);
    tbl[1]  = v(8'd128, 0, 8'd0,   4'd0, 1, 1, 1, 8'd1, 1, 8'd1);
    tbl[2]  = v(8'd200, 0, 8'd0,   4'd0, 1, 0, 0, 8'd1, 0, 8'd0);
    tbl[3]  = v(8'd200, 0, 8'd0,   4'd0, 1, 0, 0, 8'd1, 0, 8'd0);
    tbl[4]  = v(8'd200, 0, 8'd0,   4'd0, 1, 0, 0, 8'd1, 0, 8'd0);
    tbl[5]  = v(8'd200, 0, 8'd0,   4'd0, 1, 0, 0, 8'd1, 0, 8'd0);
    tbl[6]  = v(8'd128, 0, 8'd0,   4'd0, 1, 1, 1, 8'd2, 1, 8'd6);
    tbl[7]  = v(8'd128, 0, 8'd0,   4'd0, 1, 0, 0, 8'd2, 0, 8'd0);
    tbl[8]  = v(8'd128, 0, 8'd0,   4'd0, 1, 0, 0, 8'd2, 0, 8'd0);
    tbl[9]  = v(8'd128, 0, 8'd0,   4'd0, 1, 0, 0, 8'd2, 0, 8'd0);
    tbl[10] = v(8'd128, 0, 8'd0,   4'd0, 1, 0, 0, 8'd2, 0, 8'd0);
    tbl[11] = v(8'd128, 0, 8'd0,   4'd0, 1, 1, 1, 8'd3, 1, 8'd11);
    tbl[12] = v(8'd127, 1, 8'd100, 4'd0, 1, 0, 0, 8'd3, 0, 8'd0);
    tbl[13] = v(8'd150, 0, 8'd0,   4'd0, 1, 0, 0, 8'd3, 0, 8'd0);
    tbl[14] = v(8'd150, 0, 8'd0,   4'd0, 1, 0, 0, 8'd3, 0, 8'd0);
    tbl[15] = v(8'd150, 0, 8'd0,   4'd0, 1, 0, 0, 8'd3, 0, 8'd0);
    tbl[16] = v(8'd99,  0, 8'd0,   4'd0, 1, 0, 0, 8'd3, 0, 8'd0);
    tbl[17] = v(8'd100, 0, 8'd0,   4'd0, 1, 1, 1, 8'd4, 1, 8'd17);
    tbl[18] = v(8'd100, 0, 8'd0,   4'd0, 1, 1, 1, 8'd5, 1, 8'd18);
    tbl[19] = v(8'd100, 0, 8'd0,   4'd0, 0, 1, 1, 8'd6, 1, 8'd18);
    tbl[20] = v(8'd50,  0, 8'd0,   4'd0, 0, 0, 1, 8'd6, 1, 8'd18);
    tbl[21] = v(8'd50,  0, 8'd0,   4'd0, 1, 0, 1, 8'd6, 1, 8'd19);
    tbl[22] = v(8'd50,  0, 8'd0,   4'd0, 1, 0, 0, 8'd6, 0, 8'd0);
    tbl[23] = v(8'd0,   1, 8'd128, 4'd4, 1, 0, 0, 8'd6, 0, 8'd0);

    #2;
    do_reset("t0");
    for (int unsigned i = 0; i < 24; i++) begin
      membrane = tbl[i].mem; cfg_we = tbl[i].we; cfg_thresh = tbl[i].th;
      cfg_refract = tbl[i].rf; evt_ready = tbl[i].rdy;
      step();
      check($sformatf("v%0d_spike", i), spike, tbl[i].e_spk);
      check($sformatf("v%0d_valid", i), evt_valid, tbl[i].e_val);
      check($sformatf("v%0d_count", i), spike_count, tbl[i].e_cnt);
      check($sformatf("v%0d_ovf", i), overflow, 0);
      if (tbl[i].chk_ts) check($sformatf("v%0d_ts", i), evt_ts, tbl[i].e_ts);
    end
    cfg_we = 1'b0;

    // Sub-threshold membrane never fires.
    do_reset("low");
    membrane = 8'd127;
    for (int unsigned i = 0; i < 20; i++) begin
      step();
      check($sformatf("low%0d_spike", i), spike, 0);
      check($sformatf("low%0d_valid", i), evt_valid, 0);
    end

    // Five spikes with the consumer stalled: one dropped, four drained in order.
    do_reset("ovf");
    cfg_we = 1'b1; cfg_thresh = 8'd128; cfg_refract = 4'd0; evt_ready = 1'b0;
    step();
    cfg_we = 1'b0; membrane = 8'd200;
    for (int unsigned i = 0; i < 5; i++) step();
    check("ovf_flag", overflow, 1);
    check("ovf_valid", evt_valid, 1);
    check("ovf_head", evt_ts, 8'd1);
    check("ovf_count", spike_count, 8'd5);
    membrane = 8'd0; evt_ready = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      check($sformatf("drain%0d_valid", k), evt_valid, 1);
      check($sformatf("drain%0d_ts", k), evt_ts, k + 1);
      step();
    end
    check("drain_empty", evt_valid, 0);
    check("drain_ovf_sticky", overflow, 1);

    // Full queue plus a push coinciding with a pop keeps occupancy at four.
    do_reset("full");
    cfg_we = 1'b1; cfg_thresh = 8'd128; cfg_refract = 4'd0; evt_ready = 1'b0;
    step();
    cfg_we = 1'b0; membrane = 8'd200;
    for (int unsigned i = 0; i < 4; i++) step();
    check("full_head", evt_ts, 8'd1);
    evt_ready = 1'b1;
    step();
    check("full_no_ovf", overflow, 0);
    check("full_head2", evt_ts, 8'd2);
    membrane = 8'd0;
    for (int unsigned k = 0; k < 4; k++) begin
      check($sformatf("full_drain%0d_valid", k), evt_valid, 1);
      check($sformatf("full_drain%0d_ts", k), evt_ts, k + 2);
      step();
    end
    check("full_drain_empty", evt_valid, 0);

    // Zero refractory: fires every cycle and the counter saturates.
    do_reset("sat");
    cfg_we = 1'b1; cfg_thresh = 8'd128; cfg_refract = 4'd0;
    step();
    cfg_we = 1'b0; membrane = 8'd200;
    for (int unsigned i = 0; i < 260; i++) begin
      step();
      check($sformatf("sat%0d_spike", i), spike, 1);
      if (i == 253) check("sat_count_254", spike_count, 8'd254);
      if (i == 254) check("sat_count_255", spike_count, 8'd255);
    end
    check("sat_hold", spike_count, 8'd255);

    // Reset in the middle of a refractory period with a queued event.
    do_reset("mid");
    membrane = 8'd200; evt_ready = 1'b0;
    step();
    check("mid_spike", spike, 1);
    membrane = 8'd0;
    step();
    step();
    check("mid_pre_valid", evt_valid, 1);
    do_reset("mid2");
    membrane = 8'd200;
    step();
    check("post_spike", spike, 1);
    check("post_count", spike_count, 8'd1);
    check("post_valid", evt_valid, 1);
    check("post_ts", evt_ts, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
